dap_usb_transmitter: RTL and testbench
======================================

// Module: dap_usb_transmitter
// PURPOSE
//  AXI-Stream to USB IN-endpoint packet buffer: DAP response bytes are stored in a 4 KiB FIFO
//  and served to the USB device controller one whole packet at a time. Sits between the DAP
//  response path and the USB controller TX port. Re-sends the same packet if a transfer aborts.
// PARAMETERS
//  P_ENDPOINT  4'd2    IN endpoint number this instance serves
//  P_MAX_PKT   512     max USB packet bytes; longer AXIS packets split into P_MAX_PKT chunks
//  P_LEN_DEPTH 16      committed-packet length queue depth (power of 2)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, asynchronous, active-low
//  usb_endpt      in   4   endpoint currently addressed by controller
//  usb_txact      in   1   controller IN transaction active
//  usb_txpop      in   1   controller consumed usb_txdat this cycle
//  usb_txdat      out  8   byte at read pointer (registered)
//  usb_txdat_len  out  12  length of packet at queue head (0 when queue empty)
//  usb_txcork     out  1   1 = nothing to send, controller NAKs
//  fifo_full      out  1   data FIFO or length queue cannot accept a byte
//  fifo_empty     out  1   no committed packet pending
//  s_axis_tdata   in   8   response byte
//  s_axis_tvalid  in   1   byte valid
//  s_axis_tlast   in   1   last byte of DAP response
//  s_axis_tready  out  1   = !fifo_full
// BEHAVIOUR
//  Reset: all pointers/counters 0, length queue empty, read FSM IDLE; usb_txdat=0,
//   usb_txdat_len=0, usb_txcork=1, fifo_empty=1, fifo_full=0, s_axis_tready=1.
//  Storage: ram[0:4095] x8; 13-bit wptr/wptr_tmp/rptr/rptr_start, bit 12 = wrap flag.
//   full when (wptr_tmp - rptr) == 4096 or length queue full; empty when length queue empty.
//  Write side: accept when tvalid&tready: ram[wptr_tmp[11:0]]<=tdata, wptr_tmp++, wcnt++.
//   If tlast or wcnt+1==P_MAX_PKT on accept: push wcnt+1 to length queue, wptr<=wptr_tmp+1,
//   wcnt<=0 (same cycle). Uncommitted bytes never visible to USB side.
//  ep_sel = (usb_endpt==P_ENDPOINT); only ep_sel-qualified txact/txpop act.
//  Read FSM: IDLE -> ACTIVE on rising edge of txact&ep_sel with queue non-empty:
//   rptr_start<=rptr, rcnt<=0. ACTIVE: each txpop -> rptr++, rcnt++; pops beyond
//   usb_txdat_len ignored (rptr holds). ACTIVE -> IDLE on falling edge of txact&ep_sel:
//   rcnt==len -> pop length queue (packet retired); else rptr<=rptr_start (retry same packet).
//   Rising edge with empty queue: stay IDLE, cork=1 (NAK).
//  usb_txdat: 1-cycle registered read, prefetches ram[rptr_next] on pop so byte valid the
//   cycle after pop; on rollback reloads ram[rptr_start].
//  usb_txcork = queue empty; usb_txdat_len = head entry, stable throughout ACTIVE.
//  Simultaneous push and retire in one cycle: queue count unchanged, both take effect.
//  Pointer wrap at 4096 via 13-bit compare; packet may straddle address 4095->0.
//  resetn low mid-transfer: everything to reset values immediately; partial packet lost.
// TESTING
//  3-byte AXIS packet 01,02,03 tlast -> cork 1->0, len=3; txact+3 pops -> txdat 01,02,03; retire, cork=1.
//  1100-byte response -> lengths 512,512,76 queued; three IN transactions deliver in order.
//  txact falls after 2 of 3 pops -> rptr restored; next IN resends 01,02,03, len still 3.
//  Fill 4096 bytes unread -> s_axis_tready=0, fifo_full=1; one 512-byte retire -> tready=1.
//  txact on usb_endpt=1 (P_ENDPOINT=2) -> no pointer change; txact on empty queue -> cork=1.
//  Pointers pre-advanced to 4094, write 5-byte packet -> read back intact across wrap.

Source files
------------

// File: rtl/dap_usb_transmitter.sv
// Packet buffer between the DAP response stream and a USB IN endpoint: bytes are held in a
// 4 KiB ring, committed packet lengths in a small queue, and a packet is replayed on abort.
module dap_usb_transmitter #(
    parameter logic [3:0] P_ENDPOINT  = 4'd2,
    parameter int         P_MAX_PKT   = 512,
    parameter int         P_LEN_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  usb_endpt,
    input  logic        usb_txact,
    input  logic        usb_txpop,
    output logic [7:0]  usb_txdat,
    output logic [11:0] usb_txdat_len,
    output logic        usb_txcork,
    output logic        fifo_full,
    output logic        fifo_empty,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready
);
    localparam int LQ_AW = $clog2(P_LEN_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic [7:0]  ram    [0:4095];
    logic [11:0] lq_mem [0:P_LEN_DEPTH-1];

    logic [12:0] wptr_q, wptr_d, wptr_tmp_q, wptr_tmp_d;
    logic [12:0] rptr_q, rptr_d, rptr_start_q, rptr_start_d;
    logic [11:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
    logic [LQ_AW:0] lq_wptr_q, lq_wptr_d, lq_rptr_q, lq_rptr_d;
    state_t      state_q, state_d;
    logic        txact_sel_q, txact_sel_d;
    logic [7:0]  txdat_q;

    logic        ep_sel, txact_sel, pop_sel, txact_rise, txact_fall;
    logic [LQ_AW:0] lq_count;
    logic        lq_empty, lq_full, full_w, wr_en, commit;
    logic [12:0] fill;
    logic [11:0] wcnt_inc, head_len;

    assign ep_sel     = (usb_endpt == P_ENDPOINT);
    assign txact_sel  = usb_txact & ep_sel;
    assign pop_sel    = usb_txpop & ep_sel;
    assign txact_rise = txact_sel & ~txact_sel_q;
    assign txact_fall = ~txact_sel & txact_sel_q;

    assign lq_count = lq_wptr_q - lq_rptr_q;
    assign lq_empty = (lq_count == '0);
    assign lq_full  = (lq_count == (LQ_AW+1)'(P_LEN_DEPTH));
    // Extra wrap bit lets a completely full ring be told apart from an empty one.
    assign fill     = wptr_tmp_q - rptr_q;
    assign full_w   = (fill == 13'd4096) | lq_full;
    assign wr_en    = s_axis_tvalid & ~full_w;
    assign wcnt_inc = wcnt_q + 12'd1;
    assign commit   = wr_en & (s_axis_tlast | (wcnt_inc == 12'(P_MAX_PKT)));
    assign head_len = lq_mem[lq_rptr_q[LQ_AW-1:0]];

    always_comb begin
        wptr_d     = wptr_q;
        wptr_tmp_d = wptr_tmp_q;
        wcnt_d     = wcnt_q;
        lq_wptr_d  = lq_wptr_q;
        if (wr_en) begin
            wptr_tmp_d = wptr_tmp_q + 13'd1;
            wcnt_d     = wcnt_inc;
            if (commit) begin
                wptr_d    = wptr_tmp_q + 13'd1;
                wcnt_d    = '0;
                lq_wptr_d = lq_wptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rptr_d       = rptr_q;
        rptr_start_d = rptr_start_q;
        rcnt_d       = rcnt_q;
        lq_rptr_d    = lq_rptr_q;
        txact_sel_d  = txact_sel;
        case (state_q)
            S_IDLE: begin
                if (txact_rise && !lq_empty) begin
                    state_d      = S_ACTIVE;
                    rptr_start_d = rptr_q;
                    rcnt_d       = '0;
                end
            end
            S_ACTIVE: begin
                if (txact_fall) begin
                    state_d = S_IDLE;
                    // A short transfer means the host never got the packet: rewind for a resend.
                    if (rcnt_q == head_len) lq_rptr_d = lq_rptr_q + 1'b1;
                    else                    rptr_d    = rptr_start_q;
                end else if (pop_sel && (rcnt_q < head_len)) begin
                    rptr_d = rptr_q + 13'd1;
                    rcnt_d = rcnt_q + 12'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q       <= '0;
            wptr_tmp_q   <= '0;
            wcnt_q       <= '0;
            rptr_q       <= '0;
            rptr_start_q <= '0;
            rcnt_q       <= '0;
            lq_wptr_q    <= '0;
            lq_rptr_q    <= '0;
            state_q      <= S_IDLE;
            txact_sel_q  <= 1'b0;
            txdat_q      <= '0;
        end else begin
            wptr_q       <= wptr_d;
            wptr_tmp_q   <= wptr_tmp_d;
            wcnt_q       <= wcnt_d;
            rptr_q       <= rptr_d;
            rptr_start_q <= rptr_start_d;
            rcnt_q       <= rcnt_d;
            lq_wptr_q    <= lq_wptr_d;
            lq_rptr_q    <= lq_rptr_d;
            state_q      <= state_d;
            txact_sel_q  <= txact_sel_d;
            // Reading at the next pointer keeps the byte under the read pointer ready every cycle.
            txdat_q      <= ram[rptr_d[11:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)  ram[wptr_tmp_q[11:0]]       <= s_axis_tdata;
        if (commit) lq_mem[lq_wptr_q[LQ_AW-1:0]] <= wcnt_inc;
    end

    assign usb_txdat     = txdat_q;
    assign usb_txdat_len = lq_empty ? 12'd0 : head_len;
    assign usb_txcork    = lq_empty;
    assign fifo_full     = full_w;
    assign fifo_empty    = lq_empty;
    assign s_axis_tready = ~full_w;
endmodule

// File: tb/tb_dap_usb_transmitter.sv
// Directed bench for dap_usb_transmitter: packets are pushed on AXIS and read back through
// the USB IN handshake, with expected bytes taken from the bench's own record of what it sent.
module tb_dap_usb_transmitter;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  usb_endpt = 4'd2;
    logic        usb_txact = 1'b0;
    logic        usb_txpop = 1'b0;
    logic [7:0]  usb_txdat;
    logic [11:0] usb_txdat_len;
    logic        usb_txcork, fifo_full, fifo_empty, s_axis_tready;
    logic [7:0]  s_axis_tdata = 8'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    dap_usb_transmitter #(.P_ENDPOINT(4'd2), .P_MAX_PKT(512), .P_LEN_DEPTH(16)) dut (
        .clk(clk), .resetn(resetn),
        .usb_endpt(usb_endpt), .usb_txact(usb_txact), .usb_txpop(usb_txpop),
        .usb_txdat(usb_txdat), .usb_txdat_len(usb_txdat_len), .usb_txcork(usb_txcork),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int guard = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && guard < 64) begin
            tick();
            guard++;
        end
        check("send_ready", 32'(s_axis_tready), 32'd1);
        tick();
        exp_q.push_back(d);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // One IN transaction on endpoint 2 with npops pops; the packet is consumed if npops >= len.
    task automatic rx(input int npops, input int exp_len);
        usb_endpt = 4'd2;
        usb_txact = 1'b1;
        tick();
        check("rx_len", 32'(usb_txdat_len), 32'(exp_len));
        check("rx_cork", 32'(usb_txcork), 32'd0);
        for (int i = 0; i < npops; i++) begin
            if (i < exp_len) check("rx_txdat", 32'(usb_txdat), 32'(exp_q[i]));
            usb_txpop = 1'b1;
            tick();
        end
        usb_txpop = 1'b0;
        check("rx_len_hold", 32'(usb_txdat_len), 32'(exp_len));
        usb_txact = 1'b0;
        tick();
        tick();
        if (npops >= exp_len) repeat (exp_len) void'(exp_q.pop_front());
        $display("rx: pops=%0d len=%0d cork=%0d queued_bytes=%0d", npops, exp_len, usb_txcork, exp_q.size());
    endtask

    initial begin
        repeat (3) tick();
        check("rst_txdat", 32'(usb_txdat), 32'd0);
        check("rst_len", 32'(usb_txdat_len), 32'd0);
        check("rst_cork", 32'(usb_txcork), 32'd1);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        check("rst_full", 32'(fifo_full), 32'd0);
        check("rst_tready", 32'(s_axis_tready), 32'd1);
        resetn = 1'b1;
        tick();

        // Basic 3-byte packet
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        check("p3_cork", 32'(usb_txcork), 32'd0);
        check("p3_len", 32'(usb_txdat_len), 32'd3);
        check("p3_empty", 32'(fifo_empty), 32'd0);
        tick();
        rx(3, 3);
        check("p3_retired_cork", 32'(usb_txcork), 32'd1);
        check("p3_retired_len", 32'(usb_txdat_len), 32'd0);
        check("p3_retired_empty", 32'(fifo_empty), 32'd1);

        // Aborted transfer rewinds; extra pops beyond the length are ignored
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        tick();
        rx(2, 3);
        check("retry_txdat", 32'(usb_txdat), 32'h01);
        check("retry_len", 32'(usb_txdat_len), 32'd3);
        rx(4, 3);
        send_byte(8'hAA, 1'b1);
        tick();
        check("extra_pop_txdat", 32'(usb_txdat), 32'hAA);

        // Other endpoint is ignored
        usb_endpt = 4'd1;
        usb_txact = 1'b1;
        tick();
        usb_txpop = 1'b1;
        tick();
        tick();
        usb_txpop = 1'b0;
        usb_txact = 1'b0;
        tick();
        usb_endpt = 4'd2;
        check("ep_other_txdat", 32'(usb_txdat), 32'hAA);
        check("ep_other_len", 32'(usb_txdat_len), 32'd1);
        check("ep_other_cork", 32'(usb_txcork), 32'd0);
        rx(1, 1);

        // IN on an empty queue is NAKed
        usb_txact = 1'b1;
        tick();
        check("empty_in_cork", 32'(usb_txcork), 32'd1);
        check("empty_in_len", 32'(usb_txdat_len), 32'd0);
        usb_txpop = 1'b1;
        tick();
        usb_txpop = 1'b0;
        usb_txact = 1'b0;
        tick();

        // 1100-byte response splits into 512/512/76
        for (int i = 0; i < 1100; i++) send_byte(8'(i), i == 1099);
        tick();
        check("split_head_len", 32'(usb_txdat_len), 32'd512);
        rx(512, 512);
        rx(512, 512);
        rx(76, 76);
        check("split_done_cork", 32'(usb_txcork), 32'd1);

        // Fill the whole ring without reading
        for (int i = 0; i < 4096; i++) send_byte(8'(i * 7), 1'b0);
        check("fill_tready", 32'(s_axis_tready), 32'd0);
        check("fill_full", 32'(fifo_full), 32'd1);
        check("fill_len", 32'(usb_txdat_len), 32'd512);
        rx(512, 512);
        check("drain1_tready", 32'(s_axis_tready), 32'd1);
        check("drain1_full", 32'(fifo_full), 32'd0);

        // Reset in the middle of a transfer
        usb_txact = 1'b1;
        tick();
        usb_txpop = 1'b1;
        tick();
        tick();
        usb_txpop = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_cork", 32'(usb_txcork), 32'd1);
        check("midrst_empty", 32'(fifo_empty), 32'd1);
        check("midrst_full", 32'(fifo_full), 32'd0);
        check("midrst_tready", 32'(s_axis_tready), 32'd1);
        check("midrst_len", 32'(usb_txdat_len), 32'd0);
        check("midrst_txdat", 32'(usb_txdat), 32'd0);
        usb_txact = 1'b0;
        exp_q.delete();
        tick();
        resetn = 1'b1;
        tick();

        // Advance pointers to 4094, then a 5-byte packet straddles the wrap
        for (int i = 0; i < 4094; i++) send_byte(8'(i + 3), i == 4093);
        tick();
        repeat (7) rx(512, 512);
        rx(510, 510);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), i == 4);
        tick();
        rx(5, 5);
        check("wrap_done_cork", 32'(usb_txcork), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
